// File: rtl/im_pkg.sv
`default_nettype none
// ============================================================================
// Module   : im_pkg
// Brief    : Shared exception codes, default parameters, and exception helper
//            for the instruction-memory fetch unit.
// Revision : 1.0
// ============================================================================
package im_pkg;

    typedef logic [1:0] exc_t;

    localparam exc_t EXC_NONE  = 2'd0;
    localparam exc_t EXC_ALIGN = 2'd1;
    localparam exc_t EXC_RANGE = 2'd2;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    // Misalignment wins over out-of-range.
    function automatic exc_t exc_classify(input logic misaligned, input logic out_of_range);
        exc_t code;
        code = EXC_NONE;
        if (misaligned) begin
            code = EXC_ALIGN;
        end else if (out_of_range) begin
            code = EXC_RANGE;
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/im_bram.sv
`default_nettype none
// ============================================================================
// Module   : im_bram
// Brief    : Simple dual-port RAM, one write port, one enabled registered read
//            port (read-first on address collision). Block-RAM inferable.
// Revision : 1.0
// ============================================================================
module im_bram #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Contents deliberately have no reset so boot-loaded code survives reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/im_fetch.sv
`default_nettype none
// ============================================================================
// Module   : im_fetch
// Brief    : Single-stage instruction fetch with valid/ready handshake,
//            alignment/range exceptions, flush, and boot-load write port.
// Revision : 1.0
// ============================================================================
module im_fetch
    import im_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned ADDR_W    = 11,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_instr,
    output logic [31:0]       resp_pc,
    output logic [1:0]        resp_exc,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data
);

    localparam logic [32:0] c_SPAN = 33'd1 << (ADDR_W + 2);

    logic [31:0]       w_offset;
    logic              w_out_of_range;
    exc_t              w_exc;
    logic              w_accept;
    logic [ADDR_W-1:0] w_index;
    logic [31:0]       w_rdata;

    logic              r_valid;
    logic [31:0]       r_pc;
    exc_t              r_exc;
    logic              r_mem_ok;

    assign w_offset       = req_addr - BASE_ADDR;
    assign w_out_of_range = (req_addr < BASE_ADDR) || ({1'b0, w_offset} >= c_SPAN);
    assign w_exc          = exc_classify(req_addr[1:0] != 2'b00, w_out_of_range);
    assign w_index        = w_offset[ADDR_W+1:2];

    assign req_ready = flush | ~r_valid | resp_ready;
    assign w_accept  = req_valid & req_ready & ~reset;

    im_bram #(
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) u_bram (
        .clk   (clk),
        .we    (ld_en),
        .waddr (ld_addr),
        .wdata (ld_data),
        .re    (w_accept),
        .raddr (w_index),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_pc     <= 32'h0;
            r_exc    <= EXC_NONE;
            r_mem_ok <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_pc     <= req_addr;
            r_exc    <= w_exc;
            r_mem_ok <= (w_exc == EXC_NONE);
        end else if (flush | resp_ready) begin
            r_valid  <= 1'b0;
        end
    end

    // r_mem_ok is low after reset and on exceptions, selecting the NOP word.
    assign resp_valid = r_valid;
    assign resp_pc    = r_pc;
    assign resp_exc   = r_exc;
    assign resp_instr = r_mem_ok ? w_rdata : NOP_INSTR;

endmodule
`default_nettype wire

// File: tb/tb_im_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_im_fetch
// Brief    : Scoreboard testbench for im_fetch.
// Revision : 1.0
// ============================================================================
module tb_im_fetch;

    localparam int unsigned c_ADDR_W = 11;
    localparam int unsigned c_DEPTH  = 1 << c_ADDR_W;
    localparam logic [31:0] c_BASE   = 32'h0000_3000;
    localparam logic [31:0] c_NOP    = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  exc;
    } resp_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                req_valid;
    logic [31:0]         req_addr;
    logic                req_ready;
    logic                flush;
    logic                resp_valid;
    logic                resp_ready;
    logic [31:0]         resp_instr;
    logic [31:0]         resp_pc;
    logic [1:0]          resp_exc;
    logic                ld_en;
    logic [c_ADDR_W-1:0] ld_addr;
    logic [31:0]         ld_data;

    int    n_checks = 0;
    int    n_fails  = 0;
    logic  mon_en   = 1'b0;
    resp_t sb[$];
    logic [31:0] mem_model [c_DEPTH];

    always #5 clk = ~clk;

    im_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_instr (resp_instr),
        .resp_pc    (resp_pc),
        .resp_exc   (resp_exc),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic resp_t expect_of(input logic [31:0] addr);
        resp_t r;
        r.pc = addr;
        if (addr % 4 != 0) begin
            r.exc = 2'd1;
            r.instr = c_NOP;
        end else if (addr < c_BASE || addr >= c_BASE + c_DEPTH * 4) begin
            r.exc = 2'd2;
            r.instr = c_NOP;
        end else begin
            r.exc = 2'd0;
            r.instr = mem_model[(addr - c_BASE) / 4];
        end
        return r;
    endfunction

    // Front of the queue is whatever the DUT should be presenting right now.
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_valid;
            exp_valid = (sb.size() != 0);
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_valid});
            chk("req_ready", {31'b0, req_ready}, {31'b0, flush | ~exp_valid | resp_ready});
            if (exp_valid && resp_valid) begin
                chk("resp_pc", resp_pc, sb[0].pc);
                chk("resp_instr", resp_instr, sb[0].instr);
                chk("resp_exc", {30'b0, resp_exc}, {30'b0, sb[0].exc});
            end
            if (reset) begin
                sb.delete();
            end else begin
                if (exp_valid && (resp_ready || flush)) begin
                    void'(sb.pop_front());
                end
                if (req_valid && req_ready) begin
                    sb.push_back(expect_of(req_addr));
                end
            end
        end
        if (ld_en) begin
            mem_model[ld_addr] = ld_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int unsigned idx, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_addr = c_ADDR_W'(idx);
        ld_data = data;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr);
        req_valid = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; flush = 1'b0;
        resp_ready = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = 32'h0;
        tick();
        tick();
        chk("rst_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_instr", resp_instr, c_NOP);
        chk("rst_pc", resp_pc, 32'h0);
        chk("rst_exc", {30'b0, resp_exc}, 32'h0);
        mon_en = 1'b1;

        // Load while still in reset: write must land regardless.
        load(0, 32'h3C01_0001);
        reset = 1'b0;
        for (int i = 1; i < 8; i++) load(i, 32'hA000_0000 + i);
        load(c_DEPTH - 1, 32'hDEAD_BEEF);

        // Basic hit, misaligned, below-range, past-end and last-word fetches.
        resp_ready = 1'b1;
        fetch(32'h3000);
        tick();
        chk("first_instr_const", resp_pc, 32'h3000);
        fetch(32'h3002);
        fetch(32'h2FFC);
        fetch(32'h5000);
        fetch(32'h4FFC);
        tick();

        // Stall three cycles while word 1 is rewritten under the held response.
        resp_ready = 1'b0;
        fetch(32'h3004);
        req_valid = 1'b1;
        req_addr  = 32'h3008;
        ld_en = 1'b1; ld_addr = 11'd1; ld_data = 32'h5555_5555;
        for (int i = 0; i < 3; i++) tick();
        ld_en = 1'b0;
        resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        fetch(32'h3004);

        // Read-first: write and read of word 3 in the same cycle.
        ld_en = 1'b1; ld_addr = 11'd3; ld_data = 32'h7777_0003;
        fetch(32'h300C);
        ld_en = 1'b0;
        fetch(32'h300C);
        tick();

        // Flush drops a stalled response and takes the new request.
        resp_ready = 1'b0;
        fetch(32'h3000);
        tick();
        flush = 1'b1;
        fetch(32'h3010);
        flush = 1'b0;
        tick();
        chk("flush_pc", resp_pc, 32'h3010);
        resp_ready = 1'b1;
        tick();

        // Flush with no request leaves nothing behind.
        resp_ready = 1'b0;
        fetch(32'h3014);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        resp_ready = 1'b1;
        tick();

        // Full-throughput stream.
        for (int i = 0; i < 8; i++) fetch(32'h3000 + 4 * i);
        tick();

        // Reset in the middle of a stream; memory must survive.
        for (int i = 0; i < 8; i++) begin
            reset = (i == 4);
            fetch(32'h3000 + 4 * i);
        end
        reset = 1'b0;
        tick();
        fetch(32'h3000);
        fetch(32'h4FFC);
        tick();
        tick();

        chk("sb_drained", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
